// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Main-memory bus between the cache-miss arbiter and a pipelined memory.
//   The memory accepts one access on every cycle mem_en=1 (no backpressure)
//   and returns read data in issue order, one mem_rvalid per read.
//
//   mem_en      arbiter -> memory  access this cycle
//   mem_wr      arbiter -> memory  access is a write (qualified by mem_en)
//   mem_addr    arbiter -> memory  byte address, bit 0 always 0
//   mem_wdata   arbiter -> memory  write data
//   mem_rdata   memory  -> arbiter read return data
//   mem_rvalid  memory  -> arbiter mem_rdata valid
//
//   Modports: master = arbiter side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport master (
    output mem_en,
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_rvalid
  );

  modport slave (
    input  mem_en,
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_rvalid
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one pipelined main memory between the I-cache miss path, the
//   D-cache miss path and the D-side write-through store path. One
//   transaction at a time: a miss becomes an 8-word line fill, a store a
//   single-word write. D-side traffic wins arbitration; an aging flag
//   promotes a waiting I-side miss so it cannot starve.
//
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_miss_req/i_miss_addr     I line-fill request (held until i_fill_done)
//   d_miss_req/d_miss_addr     D line-fill request (held until d_fill_done)
//   d_wr_req/addr/data         store request (held until d_wr_done)
//   mem                        memory bus (mem_arbiter_if.master)
//   fill_data/fill_word        returned word and its index within the line
//   i_fill_we/d_fill_we        write strobe into the granted cache's line
//   i_fill_done/d_fill_done    pulse with the 8th returned word
//   d_wr_done                  pulse in the cycle the store is issued
//   busy                       arbiter not idle
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_miss_req,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss_req,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [15:0]       d_wr_data,

  mem_arbiter_if.master     mem,

  output logic [15:0]       fill_data,
  output logic [2:0]        fill_word,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_done,
  output logic              busy
);

  localparam int LINE_WORDS = 8;
  localparam logic [2:0] LAST_WORD = 3'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-4){1'b1}}, 4'b0000};
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    FILL_ISSUE = 2'd2,
    FILL_DRAIN = 2'd3
  } state_t;

  state_t            state;
  logic              gnt_d_q;      // current fill belongs to the D side
  logic [ADDR_W-1:0] base_q;       // line base address of the current fill
  logic [2:0]        issue_cnt;    // index of the word on the bus
  logic              issue_last_q; // word on the bus is the last of the line
  logic [2:0]        recv_cnt;     // index of the next word to return
  logic              recv_last_q;  // next return is the last of the line
  logic              age_i;        // I miss was passed over by a D grant

  logic              mem_en_q;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       mem_wdata_q;
  logic              wr_done_q;

  // ---------------------------------------------------------------------------
  // Grant selection, only consulted in IDLE.
  // ---------------------------------------------------------------------------
  logic              gnt_wr;
  logic              gnt_dm;
  logic              gnt_im;
  logic [ADDR_W-1:0] line_addr;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value held and infer a latch.
  always_comb begin
    gnt_wr = 1'b0;
    gnt_dm = 1'b0;
    gnt_im = 1'b0;
    if (i_miss_req && age_i) gnt_im = 1'b1;
    else if (d_wr_req)       gnt_wr = 1'b1;
    else if (d_miss_req)     gnt_dm = 1'b1;
    else if (i_miss_req)     gnt_im = 1'b1;
  end

  assign line_addr = (gnt_dm ? d_miss_addr : i_miss_addr) & LINE_MASK;

  // ---------------------------------------------------------------------------
  // Receive side: returns are only meaningful while a fill is outstanding;
  // stray mem_rvalid in IDLE or WRITE is dropped here.
  // ---------------------------------------------------------------------------
  logic recv_fire;
  logic recv_done;

  assign recv_fire = mem.mem_rvalid && (state == FILL_ISSUE || state == FILL_DRAIN);
  assign recv_done = recv_fire && recv_last_q;

  // ---------------------------------------------------------------------------
  // Control FSM with registered bus outputs.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      gnt_d_q      <= 1'b0;
      base_q       <= '0;
      issue_cnt    <= '0;
      issue_last_q <= 1'b0;
      recv_cnt     <= '0;
      recv_last_q  <= 1'b0;
      age_i        <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wr_done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_wr) begin
            state       <= WRITE;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= d_wr_addr & WORD_MASK;
            mem_wdata_q <= d_wr_data;
            wr_done_q   <= 1'b1;
            if (i_miss_req) age_i <= 1'b1;
          end else if (gnt_dm || gnt_im) begin
            state        <= FILL_ISSUE;
            gnt_d_q      <= gnt_dm;
            base_q       <= line_addr;
            issue_cnt    <= '0;
            issue_last_q <= 1'b0;
            recv_cnt     <= '0;
            recv_last_q  <= 1'b0;
            mem_en_q     <= 1'b1;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= line_addr;
            // A D grant over a waiting I miss ages it; an I grant clears it.
            age_i        <= gnt_dm ? (age_i | i_miss_req) : 1'b0;
          end
        end

        WRITE: begin
          state       <= IDLE;
          mem_en_q    <= 1'b0;
          mem_wr_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          wr_done_q   <= 1'b0;
        end

        FILL_ISSUE: begin
          if (issue_last_q) begin
            state      <= FILL_DRAIN;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
          end else begin
            issue_cnt    <= issue_cnt + 3'd1;
            issue_last_q <= (issue_cnt == LAST_WORD - 3'd1);
            // Base is line aligned, so OR-ing in the word offset is an add.
            mem_addr_q   <= base_q | {{(ADDR_W-4){1'b0}}, issue_cnt + 3'd1, 1'b0};
          end
        end

        FILL_DRAIN: begin
          // Only the receive side below makes progress here.
        end

        default: state <= IDLE;
      endcase

      if (recv_fire) begin
        recv_cnt    <= recv_cnt + 3'd1;
        recv_last_q <= (recv_cnt == LAST_WORD - 3'd1);
        if (recv_done) begin
          // Leaving the fill states is what stops recv_cnt reaching a 9th word.
          state       <= IDLE;
          recv_cnt    <= '0;
          recv_last_q <= 1'b0;
          mem_en_q    <= 1'b0;
          mem_addr_q  <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem.mem_en    = mem_en_q;
  assign mem.mem_wr    = mem_wr_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  // Fill outputs are combinational from mem_rvalid so the cache sees each
  // word in its return cycle; they read zero whenever nothing is received.
  assign fill_data   = recv_fire ? mem.mem_rdata : 16'h0000;
  assign fill_word   = recv_fire ? recv_cnt : 3'd0;
  assign i_fill_we   = recv_fire && !gnt_d_q;
  assign d_fill_we   = recv_fire &&  gnt_d_q;
  assign i_fill_done = recv_done && !gnt_d_q;
  assign d_fill_done = recv_done &&  gnt_d_q;
  assign d_wr_done   = wr_done_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Scoreboard bench for mem_arbiter. Each request pushes its expected bus
//   accesses and expected fill words; a behavioural memory returns reads in
//   order after a configurable latency with optional random gaps.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_miss_req, d_miss_req, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_done, busy;

  mem_arbiter_if mif ();

  mem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_miss_req  (i_miss_req),
    .i_miss_addr (i_miss_addr),
    .d_miss_req  (d_miss_req),
    .d_miss_addr (d_miss_addr),
    .d_wr_req    (d_wr_req),
    .d_wr_addr   (d_wr_addr),
    .d_wr_data   (d_wr_data),
    .mem         (mif.master),
    .fill_data   (fill_data),
    .fill_word   (fill_word),
    .i_fill_we   (i_fill_we),
    .d_fill_we   (d_fill_we),
    .i_fill_done (i_fill_done),
    .d_fill_done (d_fill_done),
    .d_wr_done   (d_wr_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic        first;
    logic        after_prev; // first access must follow previous end by 2
    int          due;        // absolute cycle of first access, -1 if unknown
  } iss_t;

  typedef struct {
    logic        side_d;
    logic [2:0]  word;
    logic [15:0] data;
  } fill_t;

  typedef struct {
    logic [15:0] addr;
    int          ready;
  } rd_t;

  iss_t iss_q[$];
  fill_t fill_q[$];
  rd_t  rd_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_iss = 0;
  int last_end = 0;
  int last_ready = 0;
  int mem_lat = 2;
  int d_words = 0;
  bit gap_mode = 0;
  bit spurious = 0;
  bit fill_open = 0;
  bit i_drop = 0, d_drop = 0, w_drop = 0;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a * 16'd7) ^ 16'h5A3C;
  endfunction

  function automatic logic [63:0] all_outs();
    return {6'b0, mif.mem_en, mif.mem_wr, mif.mem_addr, mif.mem_wdata, fill_data,
            fill_word, i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_done, busy};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_fill(input bit side_d, input logic [15:0] addr,
                           input bit after_prev, input int due);
    iss_t e;
    fill_t f;
    logic [15:0] base;
    base = addr & 16'hFFF0;
    for (int w = 0; w < 8; w++) begin
      e.wr = 1'b0; e.addr = base + 16'(2 * w); e.data = 16'h0;
      e.first = (w == 0); e.after_prev = after_prev; e.due = due;
      iss_q.push_back(e);
      f.side_d = side_d; f.word = 3'(w); f.data = mem_fn(e.addr);
      fill_q.push_back(f);
    end
  endtask

  task automatic push_store(input logic [15:0] addr, input logic [15:0] data,
                            input bit after_prev, input int due);
    iss_t e;
    e.wr = 1'b1; e.addr = addr & 16'hFFFE; e.data = data;
    e.first = 1'b1; e.after_prev = after_prev; e.due = due;
    iss_q.push_back(e);
  endtask

  // Sampled at the falling edge, well away from the active edge.
  task automatic monitor();
    iss_t  e;
    fill_t f;
    rd_t   r;
    bit    wr_now;
    int    gap;
    wr_now = 0;
    if (mif.mem_en) begin
      if (iss_q.size() == 0) check("iss_unexpected", 1, 0);
      else begin
        e = iss_q.pop_front();
        check("iss_wr", mif.mem_wr, e.wr);
        check("iss_addr", mif.mem_addr, e.addr);
        if (e.wr) check("iss_wdata", mif.mem_wdata, e.data);
        check("wr_done", d_wr_done, e.wr);
        if (e.first) begin
          if (e.due >= 0) check("grant_latency", cyc, e.due);
          else if (e.after_prev) check("regrant_latency", cyc, last_end + 2);
          if (!e.wr) fill_open = 1;
        end else begin
          check("issue_consecutive", cyc, last_iss + 1);
        end
        last_iss = cyc;
        if (e.wr) begin
          wr_now = 1;
          last_end = cyc;
        end else begin
          gap = gap_mode ? int'($urandom_range(3, 0)) : 0;
          r.addr = mif.mem_addr;
          r.ready = (last_ready + 1 + gap > cyc + mem_lat) ? last_ready + 1 + gap : cyc + mem_lat;
          last_ready = r.ready;
          rd_q.push_back(r);
        end
      end
    end else begin
      check("bus_quiet", {mif.mem_wr, mif.mem_addr, mif.mem_wdata, d_wr_done}, 0);
    end
    check("busy", busy, fill_open || wr_now);

    if (i_fill_we || d_fill_we) begin
      if (fill_q.size() == 0) check("fill_unexpected", {i_fill_we, d_fill_we}, 0);
      else begin
        f = fill_q.pop_front();
        check("fill_we", {i_fill_we, d_fill_we}, f.side_d ? 2'b01 : 2'b10);
        check("fill_word", fill_word, f.word);
        check("fill_data", fill_data, f.data);
        check("fill_done", {i_fill_done, d_fill_done},
              (f.word == 3'd7) ? (f.side_d ? 2'b01 : 2'b10) : 2'b00);
        if (f.side_d) d_words++;
        if (f.word == 3'd7) begin
          last_end = cyc;
          fill_open = 0;
        end
      end
    end else begin
      check("fill_quiet", {i_fill_done, d_fill_done, fill_word}, 0);
    end

    if (i_fill_done) i_drop = 1;
    if (d_fill_done) d_drop = 1;
    if (d_wr_done)   w_drop = 1;
  endtask

  // Requesters drop at the edge that samples their done; memory returns.
  task automatic drive();
    rd_t r;
    if (i_drop) begin i_miss_req = 1'b0; i_drop = 0; end
    if (d_drop) begin d_miss_req = 1'b0; d_drop = 0; end
    if (w_drop) begin d_wr_req = 1'b0; w_drop = 0; end
    if (rd_q.size() > 0 && rd_q[0].ready <= cyc) begin
      r = rd_q.pop_front();
      mif.mem_rvalid = 1'b1;
      mif.mem_rdata  = mem_fn(r.addr);
    end else if (spurious) begin
      mif.mem_rvalid = 1'b1;
      mif.mem_rdata  = 16'hDEAD;
    end else begin
      mif.mem_rvalid = 1'b0;
      mif.mem_rdata  = 16'($urandom);
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic flush();
    iss_q.delete();
    fill_q.delete();
    rd_q.delete();
    fill_open = 0;
    last_ready = 0;
  endtask

  task automatic quiesce(input int max_cycles);
    int n;
    n = 0;
    while ((iss_q.size() != 0 || fill_q.size() != 0 || rd_q.size() != 0 ||
            i_miss_req || d_miss_req || d_wr_req || busy) && n < max_cycles) begin
      step();
      n++;
    end
    check("quiesce_in_time", (n < max_cycles), 1);
    if (n >= max_cycles) begin
      flush();
      i_miss_req = 1'b0; d_miss_req = 1'b0; d_wr_req = 1'b0;
    end
  endtask

  task automatic wait_d_words(input int k, input int max_cycles);
    int n;
    n = 0;
    while (d_words < k && n < max_cycles) begin
      step();
      n++;
    end
    check("d_words_in_time", (d_words >= k), 1);
  endtask

  initial begin
    i_miss_req = 1'b0; d_miss_req = 1'b0; d_wr_req = 1'b0;
    i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;
    rst_n = 1'b0;
    #1;
    check("por_outputs", all_outs(), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step(); step();

    // Reset while idle, with memory noise present.
    mif.mem_rvalid = 1'b1; mif.mem_rdata = 16'hFFFF;
    #2 rst_n = 1'b0;
    #1 check("idle_reset_outputs", all_outs(), 0);
    check("idle_reset_busy", busy, 0);
    #1 rst_n = 1'b1;
    mif.mem_rvalid = 1'b0;
    step();

    // I fill alone, 2-cycle memory.
    mem_lat = 2;
    i_miss_addr = 16'h1234; i_miss_req = 1'b1;
    push_fill(0, 16'h1234, 0, cyc + 1);
    quiesce(60);

    // Single store.
    d_wr_addr = 16'h0041; d_wr_data = 16'hBEEF; d_wr_req = 1'b1;
    push_store(16'h0041, 16'hBEEF, 0, cyc + 1);
    quiesce(20);

    // I and D miss together, then a store during the D fill:
    // D first, aged I next, store last.
    mem_lat = 3; d_words = 0;
    i_miss_addr = 16'h2468; d_miss_addr = 16'h9ABC;
    i_miss_req = 1'b1; d_miss_req = 1'b1;
    push_fill(1, 16'h9ABC, 0, cyc + 1);
    push_fill(0, 16'h2468, 1, -1);
    wait_d_words(2, 40);
    d_wr_addr = 16'h0F0F; d_wr_data = 16'h1357; d_wr_req = 1'b1;
    push_store(16'h0F0F, 16'h1357, 1, -1);
    quiesce(120);

    // Returns with 0-3 idle cycles between them.
    gap_mode = 1; mem_lat = 1;
    d_miss_addr = 16'h8ABF; d_miss_req = 1'b1;
    push_fill(1, 16'h8ABF, 0, cyc + 1);
    quiesce(100);
    gap_mode = 0;

    // Spurious returns in IDLE must not strobe or advance anything.
    spurious = 1;
    repeat (3) step();
    spurious = 0;
    step();
    i_miss_addr = 16'h4000; i_miss_req = 1'b1;
    push_fill(0, 16'h4000, 0, cyc + 1);
    quiesce(60);

    // Reset after three D words; the D grant over a waiting I miss ages I.
    mem_lat = 2; d_words = 0;
    d_miss_addr = 16'hC0DE; i_miss_addr = 16'h7770;
    d_miss_req = 1'b1; i_miss_req = 1'b1;
    push_fill(1, 16'hC0DE, 0, cyc + 1);
    wait_d_words(3, 40);
    #2 rst_n = 1'b0;
    #1 check("midfill_reset_outputs", all_outs(), 0);
    flush();
    i_miss_req = 1'b0; d_miss_req = 1'b0;
    i_drop = 0; d_drop = 0; w_drop = 0;
    mif.mem_rvalid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    // With age_i cleared by reset the store wins over the I miss.
    i_miss_addr = 16'h5550; i_miss_req = 1'b1;
    d_wr_addr = 16'h2222; d_wr_data = 16'hA5A5; d_wr_req = 1'b1;
    push_store(16'h2222, 16'hA5A5, 0, cyc + 1);
    push_fill(0, 16'h5550, 1, -1);
    quiesce(60);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
